// File: rtl/bitcoin_pkg.sv
// Shared definitions for the bitcoin hash engine back end: scanner states,
// summary record layout and hash reset value.
package bitcoin_pkg;

    typedef logic [2:0] scan_state_t;

    localparam scan_state_t ST_IDLE    = 3'd0;
    localparam scan_state_t ST_ISSUE   = 3'd1;
    localparam scan_state_t ST_SCAN    = 3'd2;
    localparam scan_state_t ST_WR_MIN  = 3'd3;
    localparam scan_state_t ST_WR_IDX  = 3'd4;
    localparam scan_state_t ST_WR_FLAG = 3'd5;

    localparam int unsigned SUMMARY_MIN_OFS  = 0;
    localparam int unsigned SUMMARY_IDX_OFS  = 1;
    localparam int unsigned SUMMARY_FLAG_OFS = 2;

    localparam logic [31:0] HASH_INIT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] summary_flag_word(input logic found, input logic [15:0] nonce);
        return {found, 15'b0, nonce};
    endfunction

endpackage

// File: rtl/result_min_tracker.sv
// Running minimum of a stream of H0 words plus first-below-target capture.
// Strict compares keep the lowest index on ties and the earliest hit.
module result_min_tracker
    import bitcoin_pkg::*;
#(
    parameter int unsigned IW = 5
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_valid,
    input  logic [IW-1:0] i_idx,
    input  logic [31:0]   i_value,
    input  logic [31:0]   i_target,
    output logic [31:0]   o_min,
    output logic [IW-1:0] o_min_idx,
    output logic          o_found,
    output logic [IW-1:0] o_found_idx
);

    logic [31:0]   r_min;
    logic [IW-1:0] r_min_idx;
    logic          r_found;
    logic [IW-1:0] r_found_idx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_min       <= HASH_INIT_MAX;
            r_min_idx   <= '0;
            r_found     <= 1'b0;
            r_found_idx <= '0;
        end else if (i_clr) begin
            r_min       <= HASH_INIT_MAX;
            r_min_idx   <= '0;
            r_found     <= 1'b0;
            r_found_idx <= '0;
        end else if (i_valid) begin
            if (i_value < r_min) begin
                r_min     <= i_value;
                r_min_idx <= i_idx;
            end
            if (!r_found && (i_value < i_target)) begin
                r_found     <= 1'b1;
                r_found_idx <= i_idx;
            end
        end
    end

    assign o_min       = r_min;
    assign o_min_idx   = r_min_idx;
    assign o_found     = r_found;
    assign o_found_idx = r_found_idx;

endmodule

// File: rtl/nonce_result_scanner.sv
// Reads NUM_NONCES H0 words, tracks the minimum and first hit below target,
// then writes a 3-word summary and latches the results for the host.
module nonce_result_scanner
    import bitcoin_pkg::*;
#(
    parameter  int unsigned NUM_NONCES = 16,
    parameter  int unsigned ADDR_W     = 16,
    localparam int unsigned IW         = $clog2(NUM_NONCES) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] result_addr,
    input  logic [ADDR_W-1:0] summary_addr,
    input  logic [31:0]       target,
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    input  logic [31:0]       mem_read_data,
    output logic [31:0]       best_hash,
    output logic [IW-1:0]     best_nonce,
    output logic              found,
    output logic [IW-1:0]     found_nonce
);

    scan_state_t       r_state;
    logic [IW-1:0]     r_rd_cnt;
    logic [ADDR_W-1:0] r_result_addr;
    logic [ADDR_W-1:0] r_summary_addr;
    logic [31:0]       r_target;
    logic [31:0]       r_best_hash;
    logic [IW-1:0]     r_best_nonce;
    logic              r_found;
    logic [IW-1:0]     r_found_nonce;

    logic              w_clr;
    logic              w_valid;
    logic              w_last_read;
    logic [IW-1:0]     w_idx;
    logic [31:0]       w_min;
    logic [IW-1:0]     w_min_idx;
    logic              w_found;
    logic [IW-1:0]     w_found_idx;

    assign mem_clk     = clk;
    assign done        = (r_state == ST_IDLE);
    assign w_clr       = (r_state == ST_IDLE) && start;
    assign w_valid     = (r_state == ST_SCAN);
    // In SCAN the word arriving now was issued one cycle earlier, i.e. nonce rd_cnt-1.
    assign w_idx       = r_rd_cnt - IW'(1);
    assign w_last_read = (r_rd_cnt == IW'(NUM_NONCES));

    result_min_tracker #(
        .IW (IW)
    ) u_tracker (
        .i_clk       (clk),
        .i_rst       (reset),
        .i_clr       (w_clr),
        .i_valid     (w_valid),
        .i_idx       (w_idx),
        .i_value     (mem_read_data),
        .i_target    (r_target),
        .o_min       (w_min),
        .o_min_idx   (w_min_idx),
        .o_found     (w_found),
        .o_found_idx (w_found_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_rd_cnt       <= '0;
            r_result_addr  <= '0;
            r_summary_addr <= '0;
            r_target       <= '0;
            r_best_hash    <= HASH_INIT_MAX;
            r_best_nonce   <= '0;
            r_found        <= 1'b0;
            r_found_nonce  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_result_addr  <= result_addr;
                        r_summary_addr <= summary_addr;
                        r_target       <= target;
                        r_rd_cnt       <= '0;
                        r_state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_rd_cnt <= IW'(1);
                    r_state  <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (w_last_read) begin
                        r_state <= ST_WR_MIN;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + IW'(1);
                    end
                end
                ST_WR_MIN: r_state <= ST_WR_IDX;
                ST_WR_IDX: r_state <= ST_WR_FLAG;
                ST_WR_FLAG: begin
                    r_best_hash   <= w_min;
                    r_best_nonce  <= w_min_idx;
                    r_found       <= w_found;
                    r_found_nonce <= w_found_idx;
                    r_rd_cnt      <= '0;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        case (r_state)
            ST_ISSUE: mem_addr = r_result_addr;
            ST_SCAN: begin
                if (!w_last_read) begin
                    mem_addr = r_result_addr + ADDR_W'(r_rd_cnt);
                end
            end
            ST_WR_MIN: begin
                mem_we         = 1'b1;
                mem_addr       = r_summary_addr + ADDR_W'(SUMMARY_MIN_OFS);
                mem_write_data = w_min;
            end
            ST_WR_IDX: begin
                mem_we         = 1'b1;
                mem_addr       = r_summary_addr + ADDR_W'(SUMMARY_IDX_OFS);
                mem_write_data = 32'(w_min_idx);
            end
            ST_WR_FLAG: begin
                mem_we         = 1'b1;
                mem_addr       = r_summary_addr + ADDR_W'(SUMMARY_FLAG_OFS);
                mem_write_data = summary_flag_word(w_found, 16'(w_found_idx));
            end
            default: ;
        endcase
    end

    assign best_hash   = r_best_hash;
    assign best_nonce  = r_best_nonce;
    assign found       = r_found;
    assign found_nonce = r_found_nonce;

endmodule
